// File: rtl/adc_pkg.sv
// Shared types and timing defaults for the ADC0804 acquisition front end.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        WAIT = 2'd2,
        RD   = 2'd3
    } adc_state_t;

    localparam int DEF_SAMPLE_DIV     = 25000;
    localparam int DEF_WR_CYCLES      = 3;
    localparam int DEF_RD_CYCLES      = 5;
    localparam int DEF_TIMEOUT_CYCLES = 5000;

    // One counter width wide enough for the longest of the four intervals.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/adc_avg4.sv
// Four-sample moving average of raw ADC captures; output is held until the history is primed.
module adc_avg4 (
    input  logic       clock_25mhz,
    input  logic       reset_n,
    input  logic       clear,
    input  logic [7:0] raw,
    input  logic       raw_valid,
    output logic [7:0] avg,
    output logic       avg_valid
);

    logic [3:0][7:0] hist;
    logic [9:0]      sum;
    logic [9:0]      sum_next;
    logic [1:0]      primed;

    // Running sum: add the newest byte, drop the one falling out of the window.
    always_comb begin
        sum_next = sum + 10'(raw) - 10'(hist[3]);
    end

    always_ff @(posedge clock_25mhz) begin
        if (!reset_n) begin
            hist      <= '0;
            sum       <= '0;
            primed    <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                hist   <= '0;
                sum    <= '0;
                primed <= '0;
            end else if (raw_valid) begin
                hist <= {hist[2:0], raw};
                sum  <= sum_next;
                if (primed == 2'd3) begin
                    avg       <= sum_next[9:2];
                    avg_valid <= 1'b1;
                end else begin
                    primed <= primed + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/synchronize.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module synchronize #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic synced
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta   <= RESET_VAL;
            synced <= RESET_VAL;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/adc0804_sampler.sv
// ADC0804 sampler: periodic WR start, bounded wait for INTR, timed RD capture.
// Define ADC_AVG4_EN to present a 4-sample moving average instead of the raw byte.
module adc0804_sampler
    import adc_pkg::*;
#(
    parameter int SAMPLE_DIV     = DEF_SAMPLE_DIV,
    parameter int WR_CYCLES      = DEF_WR_CYCLES,
    parameter int RD_CYCLES      = DEF_RD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clock_25mhz,
    input  logic       reset_n,
    input  logic [7:0] adc_data,
    input  logic       adc_intr_n,
    input  logic       sensor_present,
    output logic       adc_cs_n,
    output logic       adc_rd_n,
    output logic       adc_wr_n,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       timeout_err,
    output logic       busy
);

    localparam int CW = cnt_width(SAMPLE_DIV, WR_CYCLES, RD_CYCLES, TIMEOUT_CYCLES);

    logic          intr_sync;
    logic          present_sync;
    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] step_cnt;
    logic          tick;
    adc_state_t    state;
    logic [7:0]    raw_sample;
    logic          raw_valid;

    synchronize #(.RESET_VAL(1'b1)) u_sync_intr (
        .clk     (clock_25mhz),
        .reset_n (reset_n),
        .raw     (adc_intr_n),
        .synced  (intr_sync)
    );

    synchronize #(.RESET_VAL(1'b0)) u_sync_present (
        .clk     (clock_25mhz),
        .reset_n (reset_n),
        .raw     (sensor_present),
        .synced  (present_sync)
    );

    assign tick = (tick_cnt == CW'(SAMPLE_DIV - 1));

    always_ff @(posedge clock_25mhz) begin
        if (!reset_n || tick) tick_cnt <= '0;
        else                  tick_cnt <= tick_cnt + CW'(1);
    end

    // Ticks are only looked at in IDLE, so a tick during a conversion is dropped.
    always_ff @(posedge clock_25mhz) begin
        if (!reset_n) begin
            state       <= IDLE;
            step_cnt    <= '0;
            adc_cs_n    <= 1'b1;
            adc_rd_n    <= 1'b1;
            adc_wr_n    <= 1'b1;
            raw_sample  <= '0;
            raw_valid   <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            raw_valid   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && present_sync) begin
                        state    <= WR;
                        step_cnt <= '0;
                        adc_cs_n <= 1'b0;
                        adc_wr_n <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                WR: begin
                    if (step_cnt == CW'(WR_CYCLES - 1)) begin
                        state    <= WAIT;
                        step_cnt <= '0;
                        adc_cs_n <= 1'b1;
                        adc_wr_n <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt + CW'(1);
                    end
                end
                WAIT: begin
                    // INTR is checked first so it wins on the terminal timeout cycle.
                    if (!intr_sync) begin
                        state    <= RD;
                        step_cnt <= '0;
                        adc_cs_n <= 1'b0;
                        adc_rd_n <= 1'b0;
                    end else if (step_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state       <= IDLE;
                        step_cnt    <= '0;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        step_cnt <= step_cnt + CW'(1);
                    end
                end
                RD: begin
                    if (step_cnt == CW'(RD_CYCLES - 1)) begin
                        state      <= IDLE;
                        step_cnt   <= '0;
                        adc_cs_n   <= 1'b1;
                        adc_rd_n   <= 1'b1;
                        raw_sample <= adc_data;
                        raw_valid  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        step_cnt <= step_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sample_valid is a single-cycle strobe with no backpressure: the consumer
    // must take sample in the cycle sample_valid is high.
`ifdef ADC_AVG4_EN
    logic present_q;

    always_ff @(posedge clock_25mhz) begin
        if (!reset_n) present_q <= 1'b0;
        else          present_q <= present_sync;
    end

    adc_avg4 u_avg4 (
        .clock_25mhz (clock_25mhz),
        .reset_n     (reset_n),
        .clear       (present_q && !present_sync),
        .raw         (raw_sample),
        .raw_valid   (raw_valid),
        .avg         (sample),
        .avg_valid   (sample_valid)
    );
`else
    assign sample       = raw_sample;
    assign sample_valid = raw_valid;
`endif

endmodule

// File: tb/tb_adc0804_sampler.sv
// Directed bench for adc0804_sampler: two instances (short and long timeout) driven by an ADC0804 model.
module tb_adc0804_sampler;

`ifdef ADC_AVG4_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    localparam int VPC = AVG ? 0 : 1;

    logic       clock_25mhz = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] adc_data = 8'hA5;
    logic       sensor_present = 1'b1;
    logic [1:0] intr_n = 2'b11;
    logic [1:0] cs_n, rd_n, wr_n, valid_w, tmo_w, busy_w;
    logic [7:0] sample_w [2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_wr_fall [2] = '{0, 0};
    int n_rd_fall [2] = '{0, 0};
    int n_valid [2] = '{0, 0};
    int n_timeout [2] = '{0, 0};
    int t_wr_fall [2] = '{0, 0};
    int t_wr_rise [2] = '{0, 0};
    int t_rd_fall [2] = '{0, 0};
    int t_rd_rise [2] = '{0, 0};
    int t_valid [2] = '{0, 0};
    int t_timeout [2] = '{0, 0};
    int t_intr_fall [2] = '{0, 0};
    int wr_run [2] = '{0, 0};
    int rd_run [2] = '{0, 0};
    int wr_len [2] = '{0, 0};
    int rd_len [2] = '{0, 0};
    int intr_delay [2] = '{40, 150};
    int cd [2] = '{0, 0};
    logic [1:0] wr_prev = 2'b11;
    logic [1:0] rd_prev = 2'b11;
    logic [7:0] exp_q [$];

    // clock / reset
    always #5 clock_25mhz = ~clock_25mhz;

    adc0804_sampler #(
        .SAMPLE_DIV(100), .WR_CYCLES(3), .RD_CYCLES(5), .TIMEOUT_CYCLES(50)
    ) dut (
        .clock_25mhz (clock_25mhz),
        .reset_n     (reset_n),
        .adc_data    (adc_data),
        .adc_intr_n  (intr_n[0]),
        .sensor_present (sensor_present),
        .adc_cs_n    (cs_n[0]),
        .adc_rd_n    (rd_n[0]),
        .adc_wr_n    (wr_n[0]),
        .sample      (sample_w[0]),
        .sample_valid(valid_w[0]),
        .timeout_err (tmo_w[0]),
        .busy        (busy_w[0])
    );

    adc0804_sampler #(
        .SAMPLE_DIV(100), .WR_CYCLES(3), .RD_CYCLES(5), .TIMEOUT_CYCLES(200)
    ) dut_long (
        .clock_25mhz (clock_25mhz),
        .reset_n     (reset_n),
        .adc_data    (adc_data),
        .adc_intr_n  (intr_n[1]),
        .sensor_present (sensor_present),
        .adc_cs_n    (cs_n[1]),
        .adc_rd_n    (rd_n[1]),
        .adc_wr_n    (wr_n[1]),
        .sample      (sample_w[1]),
        .sample_valid(valid_w[1]),
        .timeout_err (tmo_w[1]),
        .busy        (busy_w[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(negedge clock_25mhz);
            #1;
        end
    endtask

    // Monitor, ADC model (INTR falls intr_delay cycles after WR_n rises, clears on RD_n low), scoreboard.
    always @(negedge clock_25mhz) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!wr_n[k]) begin
                if (wr_prev[k]) begin
                    n_wr_fall[k]++;
                    t_wr_fall[k] = cyc;
                    wr_run[k] = 0;
                end
                wr_run[k]++;
            end else if (!wr_prev[k]) begin
                wr_len[k] = wr_run[k];
                t_wr_rise[k] = cyc;
            end
            if (!rd_n[k]) begin
                if (rd_prev[k]) begin
                    n_rd_fall[k]++;
                    t_rd_fall[k] = cyc;
                    rd_run[k] = 0;
                end
                rd_run[k]++;
            end else if (!rd_prev[k]) begin
                rd_len[k] = rd_run[k];
                t_rd_rise[k] = cyc;
            end
            if (valid_w[k]) begin
                n_valid[k]++;
                t_valid[k] = cyc;
            end
            if (tmo_w[k]) begin
                n_timeout[k]++;
                t_timeout[k] = cyc;
            end
            check("cs_without_strobe", 32'(!cs_n[k] && rd_n[k] && wr_n[k]), 0);
            check("strobe_without_cs", 32'((!rd_n[k] || !wr_n[k]) && cs_n[k]), 0);
            check("rd_wr_overlap", 32'(!rd_n[k] && !wr_n[k]), 0);
            if (!reset_n) begin
                cd[k] = 0;
                intr_n[k] = 1'b1;
            end else begin
                if (!rd_n[k]) intr_n[k] = 1'b1;
                if (!wr_prev[k] && wr_n[k] && intr_delay[k] != 0) begin
                    cd[k] = intr_delay[k];
                end else if (cd[k] != 0) begin
                    cd[k]--;
                    if (cd[k] == 0) begin
                        intr_n[k] = 1'b0;
                        t_intr_fall[k] = cyc;
                    end
                end
            end
            wr_prev[k] = wr_n[k];
            rd_prev[k] = rd_n[k];
        end
        if (valid_w[0]) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_valid observed %0h expected none", sample_w[0]);
            end
            if (exp_q.size() != 0) check("sb_sample", sample_w[0], exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, r, r2, base_wr, base_rd, base_v, nw1, nv1, nt1;

        // reset state
        wait_until(3);
        check("rst_cs_n", cs_n[0], 1);
        check("rst_rd_n", rd_n[0], 1);
        check("rst_wr_n", wr_n[0], 1);
        check("rst_sample", sample_w[0], 0);
        check("rst_valid", valid_w[0], 0);
        check("rst_timeout", tmo_w[0], 0);
        check("rst_busy", busy_w[0], 0);
        check("rst_busy_long", busy_w[1], 0);
        repeat (2 * VPC) exp_q.push_back(8'hA5);
        reset_n = 1'b1;
        t0 = cyc;

        // normal conversion, INTR 40 cycles after WR_n rise, data A5
        wait_until(t0 + 99);
        check("no_early_start", n_wr_fall[0], 0);
        check("idle_busy", busy_w[0], 0);
        wait_until(t0 + 100);
        check("first_wr_fall", t_wr_fall[0], t0 + 100);
        check("wr_busy", busy_w[0], 1);
        wait_until(t0 + 104);
        check("wr_len", wr_len[0], 3);
        check("wr_rise", t_wr_rise[0], t0 + 103);
        wait_until(t0 + 146);
        check("intr_to_rd", t_rd_fall[0] - t_intr_fall[0], 3);
        check("rd_fall", t_rd_fall[0], t0 + 146);
        wait_until(t0 + 152);
        check("rd_len", rd_len[0], 5);
        check("rd_rise", t_rd_rise[0], t0 + 151);
        check("valid_count_1", n_valid[0], VPC);
        check("sample_1", sample_w[0], AVG ? 8'h00 : 8'hA5);
        check("busy_after_rd", busy_w[0], 0);
`ifndef ADC_AVG4_EN
        check("valid_time_1", t_valid[0], t0 + 151);
`endif
        wait_until(t0 + 252);
        check("second_wr_fall", t_wr_fall[0], t0 + 200);
        check("wr_fall_count", n_wr_fall[0], 2);
        check("valid_count_2", n_valid[0], 2 * VPC);

        // INTR never arrives: timeout 50 cycles after entering WAIT, then retry
        intr_delay[0] = 0;
        wait_until(t0 + 352);
        check("no_early_timeout", n_timeout[0], 0);
        check("wait_busy", busy_w[0], 1);
        wait_until(t0 + 353);
        check("timeout_count", n_timeout[0], 1);
        check("timeout_time", t_timeout[0], t0 + 353);
        check("timeout_idle", busy_w[0], 0);
        wait_until(t0 + 401);
        check("retry_wr_fall", t_wr_fall[0], t0 + 400);
        check("timeout_no_valid", n_valid[0], 2 * VPC);
        check("timeout_sample_hold", sample_w[0], AVG ? 8'h00 : 8'hA5);

        // sensor absent: no strobes over 5 tick periods
        wait_until(t0 + 460);
        sensor_present = 1'b0;
        base_wr = n_wr_fall[0];
        base_rd = n_rd_fall[0];
        wait_until(t0 + 998);
        check("absent_no_wr", n_wr_fall[0], base_wr);
        check("absent_no_rd", n_rd_fall[0], base_rd);
        check("second_timeout", t_timeout[0], t0 + 453);
        intr_delay[0] = 40;
        sensor_present = 1'b1;
        wait_until(t0 + 1001);
        check("sync_latency_miss", n_wr_fall[0], base_wr);
        wait_until(t0 + 1100);
        check("present_wr_fall", t_wr_fall[0], t0 + 1100);
        repeat (VPC) exp_q.push_back(8'hA5);
        wait_until(t0 + 1120);
        sensor_present = 1'b0;
        wait_until(t0 + 1210);
        check("drop_completes", n_valid[0], 3 * VPC);
        check("drop_rd_len", rd_len[0], 5);
        check("drop_no_restart", n_wr_fall[0], base_wr + 1);

        // reset in the middle of RD
        wait_until(t0 + 1250);
        sensor_present = 1'b1;
        wait_until(t0 + 1348);
        check("in_rd", rd_n[0], 0);
        base_v = n_valid[0];
        reset_n = 1'b0;
        wait_until(t0 + 1349);
        check("midrd_cs_n", cs_n[0], 1);
        check("midrd_rd_n", rd_n[0], 1);
        check("midrd_wr_n", wr_n[0], 1);
        check("midrd_sample", sample_w[0], 0);
        check("midrd_busy", busy_w[0], 0);
        wait_until(t0 + 1351);
        reset_n = 1'b1;
        r = cyc;
        nw1 = n_wr_fall[1];
        nv1 = n_valid[1];
        nt1 = n_timeout[1];
        repeat (2 * VPC) exp_q.push_back(8'hA5);
        wait_until(r + 5);
        check("midrd_no_valid", n_valid[0], base_v);
        wait_until(r + 100);
        check("resume_wr_fall", t_wr_fall[0], r + 100);
        check("long_wr_fall", t_wr_fall[1], r + 100);
        wait_until(r + 152);
        check("resume_valid", n_valid[0], base_v + VPC);

        // conversion longer than the sample period on the long-timeout instance
        wait_until(r + 257);
        check("long_rd_fall", t_rd_fall[1], r + 256);
        check("long_wr_len", wr_len[1], 3);
        wait_until(r + 299);
        check("long_tick_dropped", n_wr_fall[1], nw1 + 1);
        check("long_rd_len", rd_len[1], 5);
        check("long_valid", n_valid[1], nv1 + VPC);
        wait_until(r + 301);
        check("long_next_wr", t_wr_fall[1], r + 300);
        check("long_no_timeout", n_timeout[1], nt1);

        // data sequence 10,20,30,40,50
        wait_until(r + 310);
        reset_n = 1'b0;
        wait_until(r + 312);
        reset_n = 1'b1;
        r2 = cyc;
        base_v = n_valid[0];
`ifdef ADC_AVG4_EN
        exp_q.push_back(8'h28);
        exp_q.push_back(8'h38);
`else
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h50);
`endif
        wait_until(r2 + 120);
        adc_data = 8'h10;
        wait_until(r2 + 220);
        adc_data = 8'h20;
        wait_until(r2 + 320);
        adc_data = 8'h30;
        wait_until(r2 + 400);
        check("seq_mid_count", n_valid[0], base_v + (AVG ? 0 : 3));
        check("seq_mid_sample", sample_w[0], AVG ? 8'h00 : 8'h30);
        wait_until(r2 + 420);
        adc_data = 8'h40;
        wait_until(r2 + 520);
        adc_data = 8'h50;
        wait_until(r2 + 560);
        check("seq_count", n_valid[0], base_v + (AVG ? 2 : 5));
        check("seq_sample", sample_w[0], AVG ? 8'h38 : 8'h50);
        check("seq_valid_time", t_valid[0], r2 + (AVG ? 552 : 551));
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc0804_sampler.md
Name: adc0804_sampler

Overview:
- Upstream acquisition stage for the heart-rate pipeline.
- Drives the level-shifted ADC0804 on the PMOD pins: CS_n, RD_n and WR_n out; INTR_n, DB[7:0] and sensor-detect in.
- Starts a conversion at a fixed sample rate and waits for end-of-conversion, then reads the byte.
- Presents the result as an 8-bit sample with a one-cycle valid strobe to downstream pulse-detection logic.

Parameters:
- SAMPLE_DIV, 25000, clock cycles between conversion starts (1 kHz at 25 MHz).
- WR_CYCLES, 3, cycles WR_n/CS_n are held low to start a conversion (120 ns, ADC0804 min 100 ns).
- RD_CYCLES, 5, cycles RD_n/CS_n are held low before data capture (200 ns, covers 135 ns access time).
- TIMEOUT_CYCLES, 5000, max cycles to wait for INTR_n low (200 us) before aborting.

Ports:
- clock_25mhz  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- adc_data  in  8  ADC DB[7:0].
- adc_intr_n  in  1  ADC end-of-conversion, async, active low.
- sensor_present  in  1  sensor-connect detect, async, high = connected.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_rd_n  out  1  ADC read strobe, active low.
- adc_wr_n  out  1  ADC start strobe, active low.
- sample  out  8  last captured sample.
- sample_valid  out  1  one-cycle pulse when sample updates.
- timeout_err  out  1  one-cycle pulse on conversion timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Synchronous, active-low reset; it applies on any clock_25mhz edge where reset_n=0, including mid-operation.
- Reset values: adc_cs_n=1, adc_rd_n=1, adc_wr_n=1, sample=0, sample_valid=0, timeout_err=0, busy=0. State=IDLE; all counters=0; synchronizer flops reset to inactive (intr=1, present=0).
- adc_intr_n and sensor_present each pass through a 2-flop synchronizer, giving 2 cycles of latency. The FSM uses only the synchronized versions.
- Tick counter is free-running: 0..SAMPLE_DIV-1, wraps to 0. tick=1 for the one cycle where count==SAMPLE_DIV-1. A tick that arrives while busy is dropped, not queued.
- All outputs are registered.
- FSM states:
  - IDLE: strobes high. On tick && present_sync -> WR.
  - WR: cs_n=0, wr_n=0 for exactly WR_CYCLES cycles -> WAIT. INTR is ignored in this state.
  - WAIT: strobes high; wait counter increments each cycle.
    - intr_sync==0 -> RD.
    - Counter reaches TIMEOUT_CYCLES-1 with INTR still high -> timeout_err pulse, go IDLE, sample unchanged.
    - If INTR falls on that same terminal cycle, INTR wins: go RD, no error.
  - RD: cs_n=0, rd_n=0 for exactly RD_CYCLES cycles.
    - On the edge that ends the last RD cycle: adc_data is captured into sample, sample_valid=1 for the following cycle, state -> IDLE (strobes high that cycle).
- Latency: tick-to-WR_n-low is 1 cycle. INTR fall to RD_n low is 3 cycles (2 synchronizer + 1).
- If sensor_present drops mid-conversion, the current conversion completes normally. No new conversion starts while present_sync=0. sample holds its last value.
- CS_n is never low while both RD_n and WR_n are high, except in the transition cycle back to IDLE, which has all three high.
- busy = (state != IDLE).

Optional Feature:
- Macro: ADC_AVG4_EN.
- Defined:
  - sample is the mean of the last 4 raw captures: 10-bit sum, sum>>2, truncated.
  - sample_valid is delayed by 1 cycle relative to the raw capture.
  - The history is cleared on reset. The first 3 captures after reset, and after present_sync falls, produce no sample_valid (priming); the 4th and later produce valid.
- Undefined: sample is the raw capture, as described above.

Decomposition:
- Package adc_pkg holds:
  - FSM state enum: IDLE, WR, WAIT, RD (2-bit).
  - Default timing constants.
  - Counter width calculation: clog2 of the largest parameter.
- Reuse the existing synchronize module for both async inputs.
- One natural sub-module, adc_avg4: 4-deep shift history, running sum, and priming counter. It is instantiated only under ADC_AVG4_EN.

Test Plan:
- SAMPLE_DIV=100, model INTR low 40 cycles after WR_n rise, data=8'hA5 -> WR_n low exactly 3 cycles, RD_n low exactly 5 cycles, sample=8'hA5 with one valid pulse, repeating every 100 cycles.
- Model never asserts INTR, TIMEOUT_CYCLES=50 -> timeout_err pulses once, 50 cycles after entering WAIT. sample holds its previous value, no valid, next tick retries.
- sensor_present=0 -> no strobe ever goes low over 5 tick periods. Raise it -> conversion starts on the first tick at least 2 cycles after the rise.
- reset_n=0 asserted mid-RD -> all strobes high on the next edge, sample=0, busy=0. After release, normal operation resumes on the next tick.
- Conversion longer than SAMPLE_DIV (INTR at 150 cycles, SAMPLE_DIV=100) -> the intervening tick is dropped, exactly one conversion is in flight, no glitch on strobes.
- ADC_AVG4_EN, captures 8'h10, 8'h20, 8'h30, 8'h40, 8'h50 -> no valid for the first 3; then 8'h28, then 8'h38.
